// File: rtl/ws2812_frame_sequencer.sv
// WS2812B frame sequencer: streams NUM_LEDS GRB pixels MSB-first into the
// per-bit waveform generator, then holds the line in return for RET_CYCLES.
module ws2812_frame_sequencer #(
   parameter int unsigned NUM_LEDS   = 8,
   parameter int unsigned RET_CYCLES = 6000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [23:0] pix_data,
   input  logic        pix_valid,
   output logic        pix_ready,
   output logic [1:0]  genMode,
   output logic        doGen,
   input  logic        genDone,
   output logic        busy,
   output logic        frame_done,
   output logic        underrun
);

   localparam int unsigned RetW = (RET_CYCLES > 1) ? $clog2(RET_CYCLES) : 1;
   localparam logic [7:0] NumPix = 8'(NUM_LEDS);
   localparam logic [7:0] LastPix = 8'(NUM_LEDS - 1);
   localparam logic [RetW-1:0] RetLast = RetW'(RET_CYCLES - 1);

   localparam logic [1:0] ModeZero = 2'b10;
   localparam logic [1:0] ModeOne  = 2'b11;
   localparam logic [1:0] ModeRet  = 2'b00;
   localparam logic [1:0] ModeNone = 2'b01;

   typedef enum logic [2:0] {StIdle, StLoad, StSend, StGap, StRet} state_e;

   state_e          state_q, state_d;
   logic [23:0]     shift_q, shift_d;
   logic [23:0]     hold_q, hold_d;
   logic            hold_full_q, hold_full_d;
   logic [4:0]      bit_idx_q, bit_idx_d;
   logic [7:0]      sent_q, sent_d;
   logic [7:0]      acc_q, acc_d;
   logic [RetW-1:0] ret_q, ret_d;
   logic            underrun_q, underrun_d;
   logic            xfer;

   // Handshake: outputs depend only on registered state, so they drop with async reset.
   assign busy      = (state_q != StIdle);
   assign pix_ready = busy && !hold_full_q && (acc_q < NumPix);
   assign xfer      = pix_valid && pix_ready;
   assign underrun  = underrun_q;

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         shift_q     <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         bit_idx_q   <= '0;
         sent_q      <= '0;
         acc_q       <= '0;
         ret_q       <= '0;
         underrun_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         bit_idx_q   <= bit_idx_d;
         sent_q      <= sent_d;
         acc_q       <= acc_d;
         ret_q       <= ret_d;
         underrun_q  <= underrun_d;
      end
   end

   // Next-state, datapath updates and generator-facing outputs.
   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      bit_idx_d   = bit_idx_q;
      sent_d      = sent_q;
      acc_d       = acc_q;
      ret_d       = ret_q;
      underrun_d  = underrun_q;
      genMode     = ModeNone;
      doGen       = 1'b0;
      frame_done  = 1'b0;

      // pix_ready is low while hold is full, so this never collides with a LOAD move.
      if (xfer) begin
         hold_d      = pix_data;
         hold_full_d = 1'b1;
         acc_d       = acc_q + 8'd1;
      end

      case (state_q)
         StIdle: begin
            if (start) begin
               state_d     = StLoad;
               underrun_d  = 1'b0;
               hold_full_d = 1'b0;
               bit_idx_d   = '0;
               sent_d      = '0;
               acc_d       = '0;
               ret_d       = '0;
            end
         end
         StLoad: begin
            if (hold_full_q) begin
               shift_d     = hold_q;
               hold_full_d = 1'b0;
               bit_idx_d   = 5'd23;
               state_d     = StSend;
            end
         end
         StSend: begin
            doGen   = 1'b1;
            genMode = shift_q[23] ? ModeOne : ModeZero;
            if (genDone) begin
               state_d = StGap;
            end
         end
         StGap: begin
            // doGen low for one cycle restarts the generator's bit counter.
            genMode = shift_q[23] ? ModeOne : ModeZero;
            if (bit_idx_q != 5'd0) begin
               shift_d   = {shift_q[22:0], 1'b0};
               bit_idx_d = bit_idx_q - 5'd1;
               state_d   = StSend;
            end else if (sent_q == LastPix) begin
               ret_d   = '0;
               state_d = StRet;
            end else begin
               sent_d  = sent_q + 8'd1;
               state_d = StLoad;
               if (!hold_full_q) begin
                  underrun_d = 1'b1;
               end
            end
         end
         StRet: begin
            genMode = ModeRet;
            if (ret_q == RetLast) begin
               frame_done = 1'b1;
               state_d    = StIdle;
            end else begin
               ret_d = ret_q + RetW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

endmodule

// File: tb/tb_ws2812_frame_sequencer.sv
// Directed bench for ws2812_frame_sequencer with NUM_LEDS=2 and a behavioural
// generator that pulses genDone 120 cycles after doGen rises.
module tb_ws2812_frame_sequencer;

   logic        clk;
   logic        reset;
   logic        start;
   logic [23:0] pix_data;
   logic        pix_valid;
   logic        pix_ready;
   logic [1:0]  genMode;
   logic        doGen;
   logic        genDone;
   logic        busy;
   logic        frame_done;
   logic        underrun;
   logic        spur;
   logic [7:0]  gcnt;

   int n_cmp;
   int n_fail;

   ws2812_frame_sequencer #(
      .NUM_LEDS   (2),
      .RET_CYCLES (6000)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .pix_data   (pix_data),
      .pix_valid  (pix_valid),
      .pix_ready  (pix_ready),
      .genMode    (genMode),
      .doGen      (doGen),
      .genDone    (genDone),
      .busy       (busy),
      .frame_done (frame_done),
      .underrun   (underrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Generator model: counter restarts whenever doGen is low.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) gcnt <= '0;
      else if (!doGen) gcnt <= '0;
      else gcnt <= gcnt + 8'd1;
   end
   assign genDone = (doGen && gcnt == 8'd120) || spur;

   typedef struct {
      logic [23:0] p0;
      logic [23:0] p1;
      logic [47:0] bits;
      int          done_k;
      bit          spur_en;
      bit          start_mid;
      bit          delay;
   } frame_t;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
      end
   endtask

   task automatic run_frame(input frame_t f);
      int idx, nb, bad_bits, last_fall, g1, g2, gx, ret_n, fd_n, fd_k;
      int nx, x0, x1, late_rdy, ndone, last_done, end_k, first_rise;
      bit prev_x, prev_dg, ended;
      idx = 0; nb = 0; bad_bits = 0; last_fall = 0; g1 = 0; g2 = 0; gx = 0;
      ret_n = 0; fd_n = 0; fd_k = -1; nx = 0; x0 = -1; x1 = -1; late_rdy = 0;
      ndone = 0; last_done = -1; end_k = -1; first_rise = -1;
      prev_x = 0; prev_dg = 0; ended = 0;
      @(negedge clk);
      start     = 1'b1;
      pix_data  = f.p0;
      pix_valid = 1'b1;
      for (int k = 0; k < 15000 && !ended; k++) begin
         @(negedge clk);
         start = f.start_mid && (k == 3000);
         spur  = f.spur_en && (k == 0 || k == 1 || k == 2930 || k == 8000);
         if (prev_x) idx++;
         pix_data  = (idx == 0) ? f.p0 : f.p1;
         pix_valid = (idx < 2) &&
                     !(f.delay && idx == 1 && (last_done < 0 || k < last_done + 500));
         prev_x = pix_valid && pix_ready;
         if (prev_x) begin
            if (nx == 0) x0 = k;
            if (nx == 1) x1 = k;
            nx++;
         end
         if (idx >= 2 && pix_ready) late_rdy++;
         if (k == 0) check("ready_after_start", 32'(pix_ready), 32'd1);
         if (k == 1) check("underrun_cleared", 32'(underrun), 32'd0);
         if (doGen && genDone) begin
            ndone++;
            if (ndone == 24 && last_done < 0) last_done = k;
         end
         if (doGen && !prev_dg) begin
            if (first_rise < 0) first_rise = k;
            if (nb > 0) begin
               if (k - last_fall == 1) g1++;
               else if (k - last_fall == 2) g2++;
               else gx++;
            end
            if (nb < 48 && genMode != (f.bits[47-nb] ? 2'b11 : 2'b10)) bad_bits++;
            nb++;
         end
         if (!doGen && prev_dg) last_fall = k;
         prev_dg = doGen;
         if (busy && genMode == 2'b00) ret_n++;
         if (frame_done) begin
            fd_n++;
            fd_k = k;
         end
         if (f.delay && k == 3200) begin
            check("wait_underrun", 32'(underrun), 32'd1);
            check("wait_dogen", 32'(doGen), 32'd0);
            check("wait_genmode", 32'(genMode), 32'd1);
            check("wait_busy", 32'(busy), 32'd1);
         end
         if (!busy) begin
            ended = 1;
            end_k = k;
         end
      end
      spur = 1'b0;
      start = 1'b0;
      pix_valid = 1'b0;
      check("frame_ended", 32'(ended), 32'd1);
      check("first_bit_cycle", first_rise, 32'd2);
      check("bit_count", nb, 32'd48);
      check("bit_values_bad", bad_bits, 32'd0);
      check("gaps_1cyc", g1, 32'd46);
      check("gaps_2cyc", g2, f.delay ? 32'd0 : 32'd1);
      check("gaps_long", gx, f.delay ? 32'd1 : 32'd0);
      check("ret_cycles", ret_n, 32'd6000);
      check("frame_done_pulses", fd_n, 32'd1);
      check("frame_done_cycle", fd_k, f.done_k);
      check("busy_fall_cycle", end_k, f.done_k + 1);
      check("accepted_words", nx, 32'd2);
      check("xfer0_cycle", x0, 32'd0);
      check("xfer1_cycle", x1, f.delay ? 32'd3428 : 32'd2);
      check("ready_after_full", late_rdy, 32'd0);
      check("underrun_end", 32'(underrun), 32'(f.delay));
   endtask

   frame_t frames[5];
   frame_t post;

   initial begin
      n_cmp = 0;
      n_fail = 0;
      reset = 1'b0;
      start = 1'b0;
      pix_valid = 1'b0;
      pix_data = '0;
      spur = 1'b0;

      frames[0] = '{24'hFF0000, 24'h00000F, 48'hFF0000_00000F, 11858, 0, 0, 0};
      frames[1] = '{24'h123456, 24'hABCDEF, 48'h123456_ABCDEF, 11858, 0, 1, 0};
      frames[2] = '{24'h000000, 24'hFFFFFF, 48'h000000_FFFFFF, 12357, 0, 0, 1};
      frames[3] = '{24'h800001, 24'h7FFFFE, 48'h800001_7FFFFE, 11858, 1, 0, 0};
      frames[4] = '{24'hA5A5A5, 24'h3C3C3C, 48'hA5A5A5_3C3C3C, 11858, 1, 1, 0};
      post      = '{24'h5A5A5A, 24'h0F0F0F, 48'h5A5A5A_0F0F0F, 11858, 0, 0, 0};

      repeat (3) @(negedge clk);
      check("rst_dogen", 32'(doGen), 32'd0);
      check("rst_genmode", 32'(genMode), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ready", 32'(pix_ready), 32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      check("rst_underrun", 32'(underrun), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("idle_ready", 32'(pix_ready), 32'd0);

      for (int i = 0; i < 5; i++) begin
         run_frame(frames[i]);
      end

      // Asynchronous reset in the middle of a bit.
      @(negedge clk);
      start = 1'b1;
      pix_valid = 1'b1;
      pix_data = 24'hC0FFEE;
      @(negedge clk);
      start = 1'b0;
      repeat (999) @(negedge clk);
      check("pre_reset_dogen", 32'(doGen), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      check("async_rst_dogen", 32'(doGen), 32'd0);
      check("async_rst_busy", 32'(busy), 32'd0);
      check("async_rst_ready", 32'(pix_ready), 32'd0);
      check("async_rst_genmode", 32'(genMode), 32'd1);
      pix_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      run_frame(post);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/ws2812_frame_sequencer.md
Name: ws2812_frame_sequencer

Overview:
- Sits directly upstream of the per-bit WS2812B waveform generator.
- Accepts a frame of NUM_LEDS 24-bit GRB pixel words over a valid/ready stream.
- Drives the generator's genMode/doGen bit by bit, MSB first, and consumes its genDone.
- Ends each frame with a latch (return) period so the strip latches the data.

Parameters:
- NUM_LEDS, 8, pixels per frame (1..255).
- RET_CYCLES, 6000, clk cycles of return/latch low time (60 us at 100 MHz; must be >= 5000).

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a frame when idle.
- pix_data  in  24  pixel word, GRB order, bit 23 sent first.
- pix_valid  in  1  pix_data is valid.
- pix_ready  out  1  sequencer accepts pix_data this cycle.
- genMode  out  2  to generator: 2'b10 zero, 2'b11 one, 2'b00 return, 2'b01 none.
- doGen  out  1  to generator: generate current bit.
- genDone  in  1  from generator: current bit period finished (one-cycle pulse).
- busy  out  1  high from accepted start until frame_done.
- frame_done  out  1  one-cycle pulse at end of return period.
- underrun  out  1  sticky; set when a bit ends with no next pixel buffered; cleared by start.

Behaviour:
- Reset (reset=0, async): state=IDLE; genMode=2'b01, doGen=0, pix_ready=0, busy=0, frame_done=0, underrun=0; all counters and buffers cleared. Mid-frame reset aborts immediately; doGen drops without waiting for a clk edge.
- Buffering: 24-bit shift register plus one 24-bit holding register with a full flag.
- pix_ready = busy && !hold_full && (accepted_count < NUM_LEDS).
- Transfer occurs on a clk edge with pix_valid && pix_ready; it loads the holding register and increments accepted_count (8 bits).
- States:
  - IDLE: outputs as reset. start=1 -> LOAD, busy=1, underrun cleared, counters zeroed. start while busy is ignored.
  - LOAD: doGen=0, genMode=2'b01. When hold_full: move hold -> shift register, clear hold_full, bit_idx=23 -> SEND. A transfer arriving in the same cycle is not allowed, because pix_ready is low while hold_full.
  - SEND: doGen=1; genMode=2'b11 if shift[23], else 2'b10. On genDone -> GAP.
  - GAP: exactly one cycle, doGen=0 (forces the generator counter to 0), genMode held. Exits:
    - bit_idx>0: shift left 1, bit_idx-1 -> SEND.
    - bit_idx==0 and sent_count==NUM_LEDS-1 -> RET.
    - bit_idx==0, otherwise: sent_count+1 -> LOAD.
  - Underrun: in GAP with bit_idx==0, another pixel due and hold empty -> set underrun; LOAD then waits as normal.
  - RET: doGen=0, genMode=2'b00, ret counter counts 0..RET_CYCLES-1, then frame_done=1 for one cycle, busy=0 -> IDLE.
- Timing: each bit occupies the generator's 121-cycle period plus one GAP cycle. With a buffered pixel, the inter-pixel dead time is GAP plus one LOAD cycle (2 cycles).
- genDone outside SEND is ignored.
- Width rules: bit_idx 5 bits; sent_count and accepted_count 8 bits; ret counter wide enough for RET_CYCLES (13 bits default). No wrap occurs inside legal parameter ranges.

Test Plan:
- NUM_LEDS=2, pixels 24'hFF0000 then 24'h00000F preloaded, generator model asserting genDone 120 cycles after doGen rises.
  - genMode sequence is 8x2'b11, 16x2'b10, 20x2'b10, 4x2'b11.
  - doGen is low exactly one cycle between bits.
  - RET lasts 6000 cycles, then frame_done pulses once and busy falls.
- Back-pressure: pix_valid held high before start.
  - pix_ready rises one cycle after start.
  - Second word is accepted only after the first moves to the shift register.
  - accepted_count stops at NUM_LEDS, after which pix_ready stays 0.
- Underrun: second pixel withheld until 500 cycles after the first pixel's last genDone.
  - underrun=1 and doGen=0, genMode=2'b01 while waiting.
  - Frame completes correctly after the pixel arrives.
  - Next start clears underrun.
- start pulsed while busy mid-SEND -> ignored; bit sequence and frame_done timing unchanged.
- reset driven low asynchronously mid-bit (between clk edges) -> doGen, busy and pix_ready go 0 immediately. After release, start gives a clean new frame beginning at bit 23.
- Spurious genDone in LOAD and RET -> no state change, no bit skipped, RET length still 6000.
